// File: rtl/onehot_scan_pkg.sv
// Shared types and defaults for the one-hot scan encoder.
// The encoder top and its priority-encoder sub-module both import this package.
package onehot_scan_pkg;

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } scan_state_t;

    localparam int ONEHOT_SCAN_N_DEFAULT = 8;

endpackage : onehot_scan_pkg

// File: rtl/onehot_scan_encoder_priority_encoder.sv
// Combinational priority encoder that returns the index of the first set bit in scan order.
// Defining ONEHOT_SCAN_MSB_FIRST_EN makes the highest set bit win; the default makes the lowest win.
module priority_encoder
    import onehot_scan_pkg::*;
#(
    parameter  int N = ONEHOT_SCAN_N_DEFAULT,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] in_bits,
    output logic [W-1:0] index,
    output logic         any
);

    always_comb begin
        index = '0;
`ifdef ONEHOT_SCAN_MSB_FIRST_EN
        // The last match in an ascending loop is the highest set bit.
        for (int i = 0; i < N; i++) begin
            if (in_bits[i]) begin
                index = W'(i);
            end
        end
`else
        // The last match in a descending loop is the lowest set bit.
        for (int i = N - 1; i >= 0; i--) begin
            if (in_bits[i]) begin
                index = W'(i);
            end
        end
`endif
    end

    assign any = |in_bits;

endmodule : priority_encoder

// File: rtl/onehot_scan_encoder.sv
// Takes an N-bit vector and emits the index of each set bit, one per output handshake.
// Scan order is lowest bit first, or highest bit first when ONEHOT_SCAN_MSB_FIRST_EN is defined.
module onehot_scan_encoder
    import onehot_scan_pkg::*;
#(
    parameter  int N = ONEHOT_SCAN_N_DEFAULT,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] i_bits,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [W-1:0] o_index,
    output logic         o_last,
    output logic         o_empty
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    scan_state_t  state_q, state_d;
    logic [N-1:0] mask_q, mask_d;
    logic         empty_q, empty_d;

    logic [W-1:0] enc_index;
    logic         enc_any;
    logic         mask_single;

    priority_encoder #(
        .N (N)
    ) u_enc (
        .in_bits (mask_q),
        .index   (enc_index),
        .any     (enc_any)
    );

    // Exactly one bit set: the mask is nonzero and clearing its lowest bit leaves nothing.
    assign mask_single = enc_any && ((mask_q & (mask_q - ONE)) == '0);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        empty_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    if (i_bits != '0) begin
                        mask_d  = i_bits;
                        state_d = S_SCAN;
                    end else begin
                        empty_d = 1'b1;
                    end
                end
            end
            S_SCAN: begin
                if (o_ready) begin
                    mask_d = mask_q & ~(ONE << enc_index);
                    if (mask_single) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                mask_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            empty_q <= empty_d;
        end
    end

    assign i_ready = (state_q == S_IDLE);
    assign o_valid = (state_q == S_SCAN);
    assign o_index = o_valid ? enc_index : '0;
    assign o_last  = o_valid && mask_single;
    assign o_empty = empty_q;

endmodule : onehot_scan_encoder

// File: tb/tb_onehot_scan_encoder.sv
// Directed bench for onehot_scan_encoder (N=8) with expected index orders for both scan builds.
module tb_onehot_scan_encoder;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         i_ready;
    logic [N-1:0] i_bits;
    logic         o_valid;
    logic         o_ready;
    logic [W-1:0] o_index;
    logic         o_last;
    logic         o_empty;

    int total = 0;
    int bad   = 0;

    onehot_scan_encoder #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_bits  (i_bits),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_index (o_index),
        .o_last  (o_last),
        .o_empty (o_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    int seq2 [3];
    int seq5_first;
    int seq6 [2];
    int prev_idx;
    int exp_idx;
    logic [N-1:0] seen;

    initial begin
`ifdef ONEHOT_SCAN_MSB_FIRST_EN
        seq2       = '{7, 5, 2};
        seq5_first = 4;
        seq6       = '{2, 1};
`else
        seq2       = '{2, 5, 7};
        seq5_first = 3;
        seq6       = '{1, 2};
`endif
        rst     = 1'b0;
        i_valid = 1'b0;
        i_bits  = '0;
        o_ready = 1'b0;

        // 1: reset state
        tick();
        tick();
        chk("rst_i_ready", int'(i_ready), 1);
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_o_index", int'(o_index), 0);
        chk("rst_o_last",  int'(o_last),  0);
        chk("rst_o_empty", int'(o_empty), 0);
        rst = 1'b1;
        tick();

        // 2: three-bit vector with o_ready held high
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_bits  = 8'b1010_0100;
        tick();
        i_valid = 1'b0;
        i_bits  = '0;
        for (int k = 0; k < 3; k++) begin
            chk("t2_o_valid", int'(o_valid), 1);
            chk("t2_i_ready", int'(i_ready), 0);
            chk("t2_o_index", int'(o_index), seq2[k]);
            chk("t2_o_last",  int'(o_last),  (k == 2) ? 1 : 0);
            tick();
        end
        chk("t2_done_i_ready", int'(i_ready), 1);
        chk("t2_done_o_valid", int'(o_valid), 0);
        chk("t2_done_o_index", int'(o_index), 0);
        chk("t2_done_o_last",  int'(o_last),  0);

        // 3: empty vector
        i_valid = 1'b1;
        i_bits  = 8'h00;
        tick();
        i_valid = 1'b0;
        chk("t3_o_empty",  int'(o_empty), 1);
        chk("t3_o_valid",  int'(o_valid), 0);
        chk("t3_i_ready",  int'(i_ready), 1);
        tick();
        chk("t3_o_empty2", int'(o_empty), 0);
        chk("t3_o_valid2", int'(o_valid), 0);
        chk("t3_i_ready2", int'(i_ready), 1);

        // 4: all ones, o_ready toggling so each index stalls one cycle then is taken
        i_valid = 1'b1;
        i_bits  = 8'hFF;
        tick();
        i_valid = 1'b0;
        i_bits  = '0;
        seen     = '0;
        prev_idx = -1;
        for (int c = 0; c < 16; c++) begin
`ifdef ONEHOT_SCAN_MSB_FIRST_EN
            exp_idx = 7 - c / 2;
`else
            exp_idx = c / 2;
`endif
            o_ready = c[0];
            chk("t4_o_valid", int'(o_valid), 1);
            chk("t4_o_index", int'(o_index), exp_idx);
            chk("t4_o_last",  int'(o_last),  (c / 2 == 7) ? 1 : 0);
            if (c[0]) begin
                chk("t4_stable", int'(o_index), prev_idx);
                seen[o_index] = 1'b1;
            end
            prev_idx = int'(o_index);
            tick();
        end
        o_ready = 1'b1;
        chk("t4_seen",     int'(seen),    255);
        chk("t4_o_valid_end", int'(o_valid), 0);
        chk("t4_i_ready_end", int'(i_ready), 1);

        // 5: reset in the middle of a scan discards the rest of the vector
        i_valid = 1'b1;
        i_bits  = 8'b0001_1000;
        tick();
        i_valid = 1'b0;
        i_bits  = '0;
        chk("t5_first", int'(o_index), seq5_first);
        tick();
        chk("t5_second_pending", int'(o_valid), 1);
        rst     = 1'b0;
        o_ready = 1'b0;
        tick();
        rst     = 1'b1;
        o_ready = 1'b1;
        chk("t5_rst_o_valid", int'(o_valid), 0);
        chk("t5_rst_i_ready", int'(i_ready), 1);
        chk("t5_rst_o_index", int'(o_index), 0);
        i_valid = 1'b1;
        i_bits  = 8'b0000_0001;
        tick();
        i_valid = 1'b0;
        i_bits  = '0;
        chk("t5_new_o_valid", int'(o_valid), 1);
        chk("t5_new_o_index", int'(o_index), 0);
        chk("t5_new_o_last",  int'(o_last),  1);
        tick();
        chk("t5_new_idle", int'(i_ready), 1);

        // 6: a new vector offered during a scan is ignored
        i_valid = 1'b1;
        i_bits  = 8'h06;
        tick();
        i_bits  = 8'h01;
        chk("t6_idx0",  int'(o_index), seq6[0]);
        chk("t6_last0", int'(o_last),  0);
        chk("t6_rdy0",  int'(i_ready), 0);
        tick();
        chk("t6_idx1",  int'(o_index), seq6[1]);
        chk("t6_last1", int'(o_last),  1);
        tick();
        i_valid = 1'b0;
        i_bits  = '0;
        chk("t6_idle_o_valid", int'(o_valid), 0);
        chk("t6_idle_i_ready", int'(i_ready), 1);
        tick();
        chk("t6_no_reload", int'(o_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_onehot_scan_encoder
